// File: rtl/dma_capture_sequencer.sv
// Capture sequencer driving dma_controller: issues a programmed number of aligned
// bursts into a DDR window, one-shot or circular. Optional watchdog: DMA_SEQ_TIMEOUT_EN.
module dma_capture_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int CNT_W          = 16,
  parameter int BURST_BYTES    = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              aclk,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cfg_base_addr_i,
  input  logic [CNT_W-1:0]  cfg_num_bursts_i,
  input  logic              cfg_circular_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              dma_enable_o,
  output logic [ADDR_W-1:0] dma_addr_o,
  input  logic              dma_finished_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  bursts_done_o,
  output logic [CNT_W-1:0]  wraps_o,
  output logic              error_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] OFS_MASK   = ADDR_W'(BURST_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  bursts_q;
  logic [CNT_W-1:0]  wraps_q;
  logic              circ_q;
  logic              done_q;

  logic [ADDR_W-1:0] base_aligned;
  logic [CNT_W-1:0]  bursts_inc;
  logic              last_burst;
  logic              timeout;

  logic              accept_start;
  logic              count_burst;
  logic              advance_addr;
  logic              wrap_pass;
  logic              done_d;
  logic              err_set;

  assign base_aligned = cfg_base_addr_i & ~OFS_MASK;
  assign bursts_inc   = bursts_q + CNT_ONE;
  assign last_burst   = (bursts_inc == num_q);

`ifdef DMA_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            error_q;

  // wd_cnt_q holds the number of cycles elapsed since the trigger cycle
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_cnt_q <= WD_W'(1);
    end else if ((state_q == S_WAIT) || (state_q == S_DRAIN)) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end

  assign timeout = ((state_q == S_WAIT) || (state_q == S_DRAIN)) &&
                   !dma_finished_i && (wd_cnt_q == WD_LIMIT);

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      error_q <= 1'b0;
    end else if (accept_start) begin
      error_q <= 1'b0;
    end else if (err_set) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    count_burst  = 1'b0;
    advance_addr = 1'b0;
    wrap_pass    = 1'b0;
    done_d       = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          accept_start = 1'b1;
          if (cfg_num_bursts_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // The trigger is already on the bus; an abort here still drains it
        state_d = abort_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (dma_finished_i) begin
          count_burst = 1'b1;
          if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (!last_burst) begin
            advance_addr = 1'b1;
            state_d      = S_ISSUE;
          end else if (circ_q) begin
            wrap_pass = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (abort_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dma_finished_i) begin
          count_burst = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (timeout) begin
          err_set = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Configuration is only meaningful after an accepted start, so it is not reset
  always_ff @(posedge aclk) begin
    if (accept_start) begin
      base_q <= base_aligned;
      num_q  <= cfg_num_bursts_i;
      circ_q <= cfg_circular_i;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      addr_q   <= '0;
      bursts_q <= '0;
      wraps_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept_start) begin
        addr_q   <= base_aligned;
        bursts_q <= '0;
        wraps_q  <= '0;
      end else begin
        if (advance_addr) begin
          addr_q <= addr_q + BURST_STEP;
        end else if (wrap_pass) begin
          addr_q <= base_q;
        end
        // A wrap counts the burst and starts the new pass in the same edge
        if (wrap_pass) begin
          bursts_q <= '0;
        end else if (count_burst) begin
          bursts_q <= bursts_inc;
        end
        if (wrap_pass && (wraps_q != {CNT_W{1'b1}})) begin
          wraps_q <= wraps_q + CNT_ONE;
        end
      end
    end
  end

  assign dma_enable_o  = (state_q == S_ISSUE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign dma_addr_o    = addr_q;
  assign bursts_done_o = bursts_q;
  assign wraps_o       = wraps_q;

endmodule

// File: tb/tb_dma_capture_sequencer.sv
// Scenario bench for dma_capture_sequencer: expected burst addresses are queued
// when a run is programmed and popped by a monitor on every dma_enable_o.
module tb_dma_capture_sequencer;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
`ifdef DMA_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
`else
  localparam int TB_TIMEOUT = 4096;
`endif

  logic              aclk = 1'b0;
  logic              rst_i = 1'b1;
  logic [ADDR_W-1:0] cfg_base_addr_i = '0;
  logic [CNT_W-1:0]  cfg_num_bursts_i = '0;
  logic              cfg_circular_i = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              dma_finished_i = 1'b0;
  logic              dma_enable_o;
  logic [ADDR_W-1:0] dma_addr_o;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  bursts_done_o;
  logic [CNT_W-1:0]  wraps_o;
  logic              error_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] cur_addr = '0;

  dma_capture_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST_BYTES(128), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .aclk(aclk), .rst_i(rst_i),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_num_bursts_i(cfg_num_bursts_i),
    .cfg_circular_i(cfg_circular_i), .start_i(start_i), .abort_i(abort_i),
    .dma_enable_o(dma_enable_o), .dma_addr_o(dma_addr_o),
    .dma_finished_i(dma_finished_i), .busy_o(busy_o), .done_o(done_o),
    .bursts_done_o(bursts_done_o), .wraps_o(wraps_o), .error_o(error_o)
  );

  always #5 aclk = ~aclk;

  // Scoreboard monitor: every trigger must match the next queued address,
  // and the address must hold while a burst is outstanding.
  initial begin
    forever begin
      @(negedge aclk);
      if (!rst_i) begin
        if (done_o) done_cnt++;
        if (dma_enable_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_enable: addr %08h, no burst expected", dma_addr_o);
          end else begin
            logic [ADDR_W-1:0] e;
            e = exp_q.pop_front();
            if (dma_addr_o !== e) begin
              errors++;
              $display("FAIL burst_addr: got %08h expected %08h", dma_addr_o, e);
            end
          end
          cur_addr = dma_addr_o;
        end else if (busy_o) begin
          checks++;
          if (dma_addr_o !== cur_addr) begin
            errors++;
            $display("FAIL addr_stable: got %08h expected %08h", dma_addr_o, cur_addr);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

  task automatic set_cfg(input logic [ADDR_W-1:0] base, input int num, input bit circ);
    cfg_base_addr_i  = base;
    cfg_num_bursts_i = CNT_W'(num);
    cfg_circular_i   = circ;
  endtask

  task automatic do_start();
    @(posedge aclk); #1 start_i = 1'b1;
    @(posedge aclk); #1 start_i = 1'b0;
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (dma_enable_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_enable: got no trigger within 200 cycles, expected one");
    end
  endtask

  // Called from the trigger-cycle negedge; finished is sampled lat edges later
  task automatic finish_after(input int lat);
    repeat (lat - 1) @(posedge aclk);
    #1 dma_finished_i = 1'b1;
    @(posedge aclk); #1 dma_finished_i = 1'b0;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d bursts outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({dma_enable_o, busy_o, done_o, error_o} !== 4'b0 || dma_addr_o !== '0 ||
        bursts_done_o !== '0 || wraps_o !== '0) begin
      errors++;
      $display("FAIL reset_values: got en=%b busy=%b done=%b err=%b addr=%08h bursts=%0d wraps=%0d, expected all 0",
               dma_enable_o, busy_o, done_o, error_o, dma_addr_o, bursts_done_o, wraps_o);
    end
    @(posedge aclk); #1 rst_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (busy_o !== 1'b0 || dma_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b en=%b, expected 0 0", busy_o, dma_enable_o);
    end
  endtask

  task automatic test_one_shot();
    bit ok;
    done_cnt = 0;
    set_cfg(32'h1000_0000, 4, 1'b0);
    exp_q.push_back(32'h1000_0000); exp_q.push_back(32'h1000_0080);
    exp_q.push_back(32'h1000_0100); exp_q.push_back(32'h1000_0180);
    do_start();
    @(negedge aclk);
    checks++;
    if (busy_o !== 1'b1 || dma_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got busy=%b en=%b, expected 1 1", busy_o, dma_enable_o);
    end
    finish_after(20);
    for (int b = 1; b < 4; b++) begin
      wait_enable(ok);
      if (!ok) return;
      finish_after(20);
    end
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== CNT_W'(4)) begin
      errors++;
      $display("FAIL one_shot_end: got done=%b busy=%b bursts=%0d, expected 1 0 4",
               done_o, busy_o, bursts_done_o);
    end
    repeat (3) @(negedge aclk);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL one_shot_done_count: got %0d expected 1", done_cnt);
    end
    check_queue_empty("one_shot");
  endtask

  task automatic test_circular();
    bit ok;
    set_cfg(32'h2000_0040, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h2000_0000);
      exp_q.push_back(32'h2000_0080);
    end
    do_start();
    for (int b = 0; b < 5; b++) begin
      wait_enable(ok);
      if (!ok) return;
      finish_after(5);
    end
    wait_enable(ok);
    if (!ok) return;
    checks++;
    if (wraps_o !== CNT_W'(2) || bursts_done_o !== CNT_W'(1)) begin
      errors++;
      $display("FAIL circular_counts: got wraps=%0d bursts=%0d, expected 2 1", wraps_o, bursts_done_o);
    end
    @(posedge aclk); #1 abort_i = 1'b1;
    @(posedge aclk); #1 abort_i = 1'b0;
    repeat (4) @(negedge aclk);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL circular_drain_wait: got busy=%b done=%b, expected 1 0", busy_o, done_o);
    end
    @(posedge aclk); #1 dma_finished_i = 1'b1;
    @(posedge aclk); #1 dma_finished_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== CNT_W'(2) || wraps_o !== CNT_W'(2)) begin
      errors++;
      $display("FAIL circular_abort_end: got done=%b busy=%b bursts=%0d wraps=%0d, expected 1 0 2 2",
               done_o, busy_o, bursts_done_o, wraps_o);
    end
    check_queue_empty("circular");
  endtask

  task automatic test_zero_and_conflict();
    bit ok;
    set_cfg(32'h3000_0000, 0, 1'b0);
    do_start();
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== '0 || wraps_o !== '0) begin
      errors++;
      $display("FAIL zero_bursts: got done=%b busy=%b bursts=%0d wraps=%0d, expected 1 0 0 0",
               done_o, busy_o, bursts_done_o, wraps_o);
    end
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: got done=%b expected 0", done_o);
    end
    set_cfg(32'h3000_0000, 3, 1'b0);
    @(posedge aclk); #1 start_i = 1'b1; abort_i = 1'b1;
    @(posedge aclk); #1 start_i = 1'b0; abort_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_conflict: got busy=%b done=%b, expected 0 0", busy_o, done_o);
    end
    set_cfg(32'h3000_0000, 1, 1'b0);
    exp_q.push_back(32'h3000_0000);
    do_start();
    wait_enable(ok);
    if (!ok) return;
    set_cfg(32'h4000_0000, 3, 1'b1);
    do_start();
    @(negedge aclk);
    checks++;
    if (busy_o !== 1'b1 || bursts_done_o !== '0) begin
      errors++;
      $display("FAIL start_while_busy: got busy=%b bursts=%0d, expected 1 0", busy_o, bursts_done_o);
    end
    @(posedge aclk); #1 dma_finished_i = 1'b1;
    @(posedge aclk); #1 dma_finished_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== CNT_W'(1)) begin
      errors++;
      $display("FAIL busy_run_end: got done=%b busy=%b bursts=%0d, expected 1 0 1",
               done_o, busy_o, bursts_done_o);
    end
    check_queue_empty("conflict");
  endtask

  task automatic test_abort_issue();
    bit ok;
    set_cfg(32'h5000_0000, 3, 1'b0);
    exp_q.push_back(32'h5000_0000);
    @(posedge aclk); #1 start_i = 1'b1;
    @(posedge aclk); #1 start_i = 1'b0; abort_i = 1'b1;
    @(negedge aclk);
    checks++;
    if (dma_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue_enable: got en=%b expected 1", dma_enable_o);
    end
    @(posedge aclk); #1 abort_i = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue_drain: got done=%b busy=%b, expected 0 1", done_o, busy_o);
    end
    @(posedge aclk); #1 dma_finished_i = 1'b1;
    @(posedge aclk); #1 dma_finished_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== CNT_W'(1)) begin
      errors++;
      $display("FAIL abort_issue_end: got done=%b busy=%b bursts=%0d, expected 1 0 1",
               done_o, busy_o, bursts_done_o);
    end
    set_cfg(32'h6000_0000, 3, 1'b0);
    exp_q.push_back(32'h6000_0000);
    do_start();
    wait_enable(ok);
    if (!ok) return;
    repeat (3) @(posedge aclk);
    #1 dma_finished_i = 1'b1; abort_i = 1'b1;
    @(posedge aclk); #1 dma_finished_i = 1'b0; abort_i = 1'b0;
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bursts_done_o !== CNT_W'(1)) begin
      errors++;
      $display("FAIL abort_finish_same_cycle: got done=%b busy=%b bursts=%0d, expected 1 0 1",
               done_o, busy_o, bursts_done_o);
    end
    check_queue_empty("abort_issue");
  endtask

  task automatic test_addr_wrap();
    bit ok;
    set_cfg(32'hFFFF_FF80, 2, 1'b0);
    exp_q.push_back(32'hFFFF_FF80);
    exp_q.push_back(32'h0000_0000);
    do_start();
    for (int b = 0; b < 2; b++) begin
      wait_enable(ok);
      if (!ok) return;
      finish_after(3);
    end
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || bursts_done_o !== CNT_W'(2)) begin
      errors++;
      $display("FAIL addr_wrap_end: got done=%b bursts=%0d, expected 1 2", done_o, bursts_done_o);
    end
    check_queue_empty("addr_wrap");
  endtask

`ifdef DMA_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok;
    set_cfg(32'h7000_0000, 1, 1'b0);
    exp_q.push_back(32'h7000_0000);
    do_start();
    wait_enable(ok);
    if (!ok) return;
    repeat (63) @(negedge aclk);
    checks++;
    if (error_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_early: got err=%b done=%b, expected 0 0", error_o, done_o);
    end
    @(negedge aclk);
    checks++;
    if (error_o !== 1'b1 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_fire: got err=%b done=%b busy=%b, expected 1 1 0", error_o, done_o, busy_o);
    end
    exp_q.push_back(32'h7000_0000);
    do_start();
    @(negedge aclk);
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear: got err=%b expected 0", error_o);
    end
    finish_after(5);
    @(negedge aclk);
    check_queue_empty("watchdog");
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_circular();
    test_zero_and_conflict();
    test_abort_issue();
    test_addr_wrap();
`ifdef DMA_SEQ_TIMEOUT_EN
    test_watchdog();
`endif
    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
